// File: rtl/fpnew_result_rob_if.sv
// rtl/fpnew_result_rob_if.sv - allocation, writeback, retire and flush signal bundle for fpnew_result_rob
interface fpnew_result_rob_if #(
    parameter int NumChannels = 5,
    parameter int Depth       = 8,
    parameter int Width       = 64,
    parameter int TagWidth    = 1
);
    localparam int IdW = $clog2(Depth);

    logic                                alloc_valid_i;
    logic [TagWidth-1:0]                 alloc_tag_i;
    logic                                alloc_ready_o;
    logic [IdW-1:0]                      alloc_id_o;

    logic [NumChannels-1:0]              ch_valid_i;
    logic [NumChannels-1:0][IdW-1:0]     ch_id_i;
    logic [NumChannels-1:0][Width-1:0]   ch_result_i;
    logic [NumChannels-1:0][4:0]         ch_status_i;
    logic [NumChannels-1:0]              ch_ready_o;

    logic                                out_valid_o;
    logic                                out_ready_i;
    logic [Width-1:0]                    out_result_o;
    logic [4:0]                          out_status_o;
    logic [TagWidth-1:0]                 out_tag_o;

    logic                                flush_i;
    logic                                busy_o;
    logic [IdW:0]                        count_o;

    modport master (
        output alloc_valid_i, alloc_tag_i,
        input  alloc_ready_o, alloc_id_o,
        output ch_valid_i, ch_id_i, ch_result_i, ch_status_i,
        input  ch_ready_o,
        input  out_valid_o, out_result_o, out_status_o, out_tag_o,
        output out_ready_i,
        output flush_i,
        input  busy_o, count_o
    );

    modport slave (
        input  alloc_valid_i, alloc_tag_i,
        output alloc_ready_o, alloc_id_o,
        input  ch_valid_i, ch_id_i, ch_result_i, ch_status_i,
        output ch_ready_o,
        output out_valid_o, out_result_o, out_status_o, out_tag_o,
        input  out_ready_i,
        input  flush_i,
        output busy_o, count_o
    );
endinterface

// File: rtl/fpnew_result_rob.sv
// rtl/fpnew_result_rob.sv - in-order result reorder buffer for out-of-order FP opgroup writebacks
// Optional head forwarding of same-cycle writebacks: define FPNEW_ROB_BYPASS_EN.
module fpnew_result_rob #(
    parameter int NumChannels = 5,
    parameter int Depth       = 8,
    parameter int Width       = 64,
    parameter int TagWidth    = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fpnew_result_rob_if.slave bus
);
    localparam int IdW = $clog2(Depth);
    typedef logic [IdW:0] ptr_t;

    ptr_t                r_head;
    ptr_t                r_tail;
    logic [Depth-1:0]    r_alloc;
    logic [Depth-1:0]    r_done;
    logic [TagWidth-1:0] r_tag    [Depth];
    logic [Width-1:0]    r_result [Depth];
    logic [4:0]          r_status [Depth];

    ptr_t                   w_count;
    logic                   w_empty;
    logic                   w_full;
    logic [IdW-1:0]         w_head_idx;
    logic [IdW-1:0]         w_tail_idx;
    logic                   w_alloc_ready;
    logic                   w_alloc_fire;
    logic [Depth-1:0]       w_claimed;
    logic [NumChannels-1:0] w_ch_ready;
    logic [NumChannels-1:0] w_ch_accept;
    logic                   w_stored_valid;
    logic                   w_head_valid;
    logic [Width-1:0]       w_head_result;
    logic [4:0]             w_head_status;
    logic                   w_retire;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_count       = r_tail - r_head;
    assign w_empty       = (w_count == '0);
    assign w_full        = (w_count == ptr_t'(Depth));
    assign w_head_idx    = r_head[IdW-1:0];
    assign w_tail_idx    = r_tail[IdW-1:0];
    assign w_alloc_ready = !w_full && !bus.flush_i;
    assign w_alloc_fire  = bus.alloc_valid_i && w_alloc_ready;

    // The first valid channel naming an entry claims it; later ones see it taken.
    always_comb begin
        w_claimed   = '0;
        w_ch_ready  = '0;
        w_ch_accept = '0;
        for (int c = 0; c < NumChannels; c++) begin
            w_ch_ready[c]  = !bus.flush_i && !rst_i
                             && r_alloc[bus.ch_id_i[c]]
                             && !r_done[bus.ch_id_i[c]]
                             && !w_claimed[bus.ch_id_i[c]];
            w_ch_accept[c] = w_ch_ready[c] && bus.ch_valid_i[c];
            if (bus.ch_valid_i[c]) begin
                w_claimed[bus.ch_id_i[c]] = 1'b1;
            end
        end
    end

    assign w_stored_valid = !bus.flush_i && !rst_i && !w_empty && r_done[w_head_idx];

`ifdef FPNEW_ROB_BYPASS_EN
    logic             w_byp_hit;
    logic [Width-1:0] w_byp_result;
    logic [4:0]       w_byp_status;

    // Descending scan so the lowest-indexed accepted channel wins.
    always_comb begin
        w_byp_hit    = 1'b0;
        w_byp_result = '0;
        w_byp_status = '0;
        for (int c = NumChannels - 1; c >= 0; c--) begin
            if (w_ch_accept[c] && (bus.ch_id_i[c] == w_head_idx)) begin
                w_byp_hit    = 1'b1;
                w_byp_result = bus.ch_result_i[c];
                w_byp_status = bus.ch_status_i[c];
            end
        end
    end

    assign w_head_valid  = w_stored_valid || w_byp_hit;
    assign w_head_result = w_stored_valid ? r_result[w_head_idx] : w_byp_result;
    assign w_head_status = w_stored_valid ? r_status[w_head_idx] : w_byp_status;
`else
    assign w_head_valid  = w_stored_valid;
    assign w_head_result = r_result[w_head_idx];
    assign w_head_status = r_status[w_head_idx];
`endif

    assign w_retire = w_head_valid && bus.out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
            for (int i = 0; i < Depth; i++) begin
                r_tag[i]    <= '0;
                r_result[i] <= '0;
                r_status[i] <= '0;
            end
        end else if (bus.flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_alloc <= '0;
            r_done  <= '0;
        end else begin
            // A writeback forwarded straight out of the head is never stored.
            for (int c = 0; c < NumChannels; c++) begin
                if (w_ch_accept[c] && !(w_retire && (bus.ch_id_i[c] == w_head_idx))) begin
                    r_result[bus.ch_id_i[c]] <= bus.ch_result_i[c];
                    r_status[bus.ch_id_i[c]] <= bus.ch_status_i[c];
                    r_done[bus.ch_id_i[c]]   <= 1'b1;
                end
            end
            if (w_retire) begin
                r_alloc[w_head_idx] <= 1'b0;
                r_done[w_head_idx]  <= 1'b0;
                r_head              <= r_head + ptr_t'(1);
            end
            if (w_alloc_fire) begin
                r_alloc[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= 1'b0;
                r_tag[w_tail_idx]   <= bus.alloc_tag_i;
                r_tail              <= r_tail + ptr_t'(1);
            end
        end
    end

    assign bus.alloc_ready_o = w_alloc_ready;
    assign bus.alloc_id_o    = w_tail_idx;
    assign bus.ch_ready_o    = w_ch_ready;
    assign bus.out_valid_o   = w_head_valid;
    assign bus.out_result_o  = w_head_valid ? w_head_result     : '0;
    assign bus.out_status_o  = w_head_valid ? w_head_status     : '0;
    assign bus.out_tag_o     = w_head_valid ? r_tag[w_head_idx] : '0;
    assign bus.busy_o        = !w_empty;
    assign bus.count_o       = w_count;
endmodule
